// File: rtl/vga_timing_pkg.sv
// Shared constants, types and elaboration helpers for the VGA timing generator.
// Defaults describe 640x480@60 with a 25 MHz pixel rate derived from clock_50.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_PIPE_DLY = 2;
    localparam int DEF_CW       = 10;
    localparam int MAX_PIPE_DLY = 15;

    // Raw (active-high) timing bundle carried through the delay line.
    typedef struct packed {
        logic hs;
        logic vs;
        logic video;
    } sync_bus_t;

    localparam int SYNC_BUS_W = $bits(sync_bus_t);

    function automatic int calc_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Number of bits needed to count 0..value-1 (0 for value<=1).
    function automatic int clog2_int(input int value);
        int r;
        r = 0;
        for (int b = 0; b < 31; b++) begin
            if ((32'sd1 <<< b) < value) begin
                r = b + 1;
            end
        end
        return r;
    endfunction

    function automatic bit in_window(input int pos, input int first, input int len);
        return (pos >= first) && (pos < first + len);
    endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Pixel-tick-advanced shift register aligning sync/blank with downstream pipeline latency.
// DEPTH=0 degenerates to a wire so the raw decode reaches the pins directly.
module sync_delay_line #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock_50,
    input  logic             reset_key,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_r [DEPTH];

            // Shift register: advances one stage per pixel tick, holds otherwise.
            always_ff @(posedge clock_50) begin
                if (!reset_key) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_r[i] <= RESET_VAL;
                    end
                end else if (shift_en) begin
                    stage_r[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_r[i] <= stage_r[i];
                    end
                end
            end

            assign q = stage_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-enable divider, h/v counters, sync decode,
// frame/line strobes and a programmable sync/blank delay line, all on clock_50.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int PIPE_DLY = DEF_PIPE_DLY,
    parameter int CW       = DEF_CW
) (
    input  logic          clock_50,
    input  logic          reset_key,
    input  logic          enable,
    output logic          pixel_tick,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          video_on,
    output logic          video_on_d,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL  = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DW       = (CLK_DIV > 1) ? clog2_int(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    generate
        if (CLK_DIV < 1) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV must be >= 1");
        end
        if ((clog2_int(H_TOTAL) > CW) || (clog2_int(V_TOTAL) > CW)) begin : g_bad_cw
            $error("vga_timing_gen: CW too small for H_TOTAL-1 / V_TOTAL-1");
        end
        if ((PIPE_DLY < 0) || (PIPE_DLY > MAX_PIPE_DLY)) begin : g_bad_dly
            $error("vga_timing_gen: PIPE_DLY must be within 0..15");
        end
    endgenerate

    logic [DW-1:0] div_r;
    logic [CW-1:0] h_cnt_r;
    logic [CW-1:0] v_cnt_r;
    logic          tick_s;
    logic          h_wrap_s;
    logic          v_wrap_s;
    logic          video_on_s;
    sync_bus_t     raw_s;
    sync_bus_t     dly_s;

    // Reset is folded into the tick so no strobe escapes while reset_key is low.
    assign tick_s   = enable & reset_key & (div_r == DIV_LAST);
    assign h_wrap_s = (h_cnt_r == H_LAST);
    assign v_wrap_s = (v_cnt_r == V_LAST);

    // Pixel-enable divider: counts enabled clocks modulo CLK_DIV.
    always_ff @(posedge clock_50) begin
        if (!reset_key) begin
            div_r <= '0;
        end else if (enable) begin
            div_r <= (div_r == DIV_LAST) ? '0 : div_r + DW'(1);
        end else begin
            div_r <= div_r;
        end
    end

    // Horizontal/vertical position counters; both may wrap on the same tick.
    always_ff @(posedge clock_50) begin
        if (!reset_key) begin
            h_cnt_r <= '0;
            v_cnt_r <= '0;
        end else if (tick_s) begin
            h_cnt_r <= h_wrap_s ? '0 : h_cnt_r + CW'(1);
            if (h_wrap_s) begin
                v_cnt_r <= v_wrap_s ? '0 : v_cnt_r + CW'(1);
            end else begin
                v_cnt_r <= v_cnt_r;
            end
        end else begin
            h_cnt_r <= h_cnt_r;
            v_cnt_r <= v_cnt_r;
        end
    end

    assign video_on_s = (h_cnt_r < H_VIS) && (v_cnt_r < V_VIS);

    // Raw sync/blank decode of the current position, kept active-high until the pins.
    always_comb begin
        raw_s       = '0;
        raw_s.hs    = (h_cnt_r >= HS_FIRST) && (h_cnt_r <= HS_LAST);
        raw_s.vs    = (v_cnt_r >= VS_FIRST) && (v_cnt_r <= VS_LAST);
        raw_s.video = video_on_s;
    end

    sync_delay_line #(
        .WIDTH     (SYNC_BUS_W),
        .DEPTH     (PIPE_DLY),
        .RESET_VAL ({SYNC_BUS_W{1'b0}})
    ) u_sync_delay_line (
        .clock_50  (clock_50),
        .reset_key (reset_key),
        .shift_en  (tick_s),
        .d         (raw_s),
        .q         (dly_s)
    );

    assign pixel_tick  = tick_s;
    assign pixel_x     = h_cnt_r;
    assign pixel_y     = v_cnt_r;
    assign video_on    = video_on_s;
    assign line_start  = tick_s & (h_cnt_r == '0);
    assign frame_start = tick_s & (h_cnt_r == '0) & (v_cnt_r == '0);
    assign video_on_d  = dly_s.video;
    assign vga_hs      = dly_s.hs ? HS_POL : ~HS_POL;
    assign vga_vs      = dly_s.vs ? VS_POL : ~VS_POL;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations driven by shared random enable/reset
// stimulus, each checked every cycle against an arithmetic model of the timing rules.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_key;
    logic enable;

    int checks   = 0;
    int failures = 0;

    // Configurations: 0 = small, CLK_DIV 2, delay 2; 1 = small, high-true sync, CLK_DIV 1,
    // no delay; 2 = the 640x480 defaults.
    localparam int P_HA[3] = '{8, 10, 640};
    localparam int P_HF[3] = '{2, 1, 16};
    localparam int P_HS[3] = '{3, 2, 96};
    localparam int P_HB[3] = '{2, 3, 48};
    localparam int P_VA[3] = '{4, 5, 480};
    localparam int P_VF[3] = '{1, 2, 10};
    localparam int P_VS[3] = '{2, 1, 2};
    localparam int P_VB[3] = '{1, 1, 33};
    localparam int P_HP[3] = '{0, 1, 0};
    localparam int P_VP[3] = '{0, 1, 0};
    localparam int P_CD[3] = '{2, 1, 2};
    localparam int P_PD[3] = '{2, 0, 2};

    logic       tick_a, vo_a, vod_a, hs_a, vs_a, ls_a, fs_a;
    logic [3:0] px_a, py_a;
    logic       tick_b, vo_b, vod_b, hs_b, vs_b, ls_b, fs_b;
    logic [4:0] px_b, py_b;
    logic       tick_c, vo_c, vod_c, hs_c, vs_c, ls_c, fs_c;
    logic [9:0] px_c, py_c;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2), .PIPE_DLY(2), .CW(4)
    ) u_a (
        .clock_50(clk), .reset_key(reset_key), .enable(enable),
        .pixel_tick(tick_a), .pixel_x(px_a), .pixel_y(py_a), .video_on(vo_a),
        .video_on_d(vod_a), .vga_hs(hs_a), .vga_vs(vs_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(10), .H_FP(1), .H_SYNC(2), .H_BP(3),
        .V_ACTIVE(5), .V_FP(2), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .PIPE_DLY(0), .CW(5)
    ) u_b (
        .clock_50(clk), .reset_key(reset_key), .enable(enable),
        .pixel_tick(tick_b), .pixel_x(px_b), .pixel_y(py_b), .video_on(vo_b),
        .video_on_d(vod_b), .vga_hs(hs_b), .vga_vs(vs_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    vga_timing_gen u_c (
        .clock_50(clk), .reset_key(reset_key), .enable(enable),
        .pixel_tick(tick_c), .pixel_x(px_c), .pixel_y(py_c), .video_on(vo_c),
        .video_on_d(vod_c), .vga_hs(hs_c), .vga_vs(vs_c),
        .line_start(ls_c), .frame_start(fs_c)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model state: enabled clocks since the last reset. Every output follows from it.
    int en_cnt[3];
    bit valid = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset_key) en_cnt[i] <= 0;
            else if (enable) en_cnt[i] <= en_cnt[i] + 1;
        end
        if (!reset_key) valid <= 1'b1;
    end

    task automatic model_check(input int i, input int gx, input int gy, input int gtick,
                               input int gvo, input int gvod, input int ghs, input int gvs,
                               input int gls, input int gfs);
        int ht, vt, d, n, h, v, m, mh, mv;
        int e_tick, e_vo, e_vod, e_hs, e_vs;
        ht = P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i];
        vt = P_VA[i] + P_VF[i] + P_VS[i] + P_VB[i];
        d  = P_CD[i];
        n  = en_cnt[i] / d;
        h  = n % ht;
        v  = (n / ht) % vt;
        e_tick = (reset_key && enable && (en_cnt[i] % d == d - 1)) ? 1 : 0;
        e_vo   = (h < P_HA[i] && v < P_VA[i]) ? 1 : 0;
        e_hs = 0; e_vs = 0; e_vod = 0;
        if (n >= P_PD[i]) begin
            m  = n - P_PD[i];
            mh = m % ht;
            mv = (m / ht) % vt;
            e_hs  = (mh >= P_HA[i] + P_HF[i] && mh < P_HA[i] + P_HF[i] + P_HS[i]) ? 1 : 0;
            e_vs  = (mv >= P_VA[i] + P_VF[i] && mv < P_VA[i] + P_VF[i] + P_VS[i]) ? 1 : 0;
            e_vod = (mh < P_HA[i] && mv < P_VA[i]) ? 1 : 0;
        end
        e_hs = e_hs ? P_HP[i] : 1 - P_HP[i];
        e_vs = e_vs ? P_VP[i] : 1 - P_VP[i];
        chk($sformatf("u%0d.pixel_x", i), gx, h);
        chk($sformatf("u%0d.pixel_y", i), gy, v);
        chk($sformatf("u%0d.pixel_tick", i), gtick, e_tick);
        chk($sformatf("u%0d.video_on", i), gvo, e_vo);
        chk($sformatf("u%0d.video_on_d", i), gvod, e_vod);
        chk($sformatf("u%0d.vga_hs", i), ghs, e_hs);
        chk($sformatf("u%0d.vga_vs", i), gvs, e_vs);
        chk($sformatf("u%0d.line_start", i), gls, (e_tick && h == 0) ? 1 : 0);
        chk($sformatf("u%0d.frame_start", i), gfs, (e_tick && h == 0 && v == 0) ? 1 : 0);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (valid) begin
            model_check(0, int'(px_a), int'(py_a), int'(tick_a), int'(vo_a), int'(vod_a),
                        int'(hs_a), int'(vs_a), int'(ls_a), int'(fs_a));
            model_check(1, int'(px_b), int'(py_b), int'(tick_b), int'(vo_b), int'(vod_b),
                        int'(hs_b), int'(vs_b), int'(ls_b), int'(fs_b));
            model_check(2, int'(px_c), int'(py_c), int'(tick_c), int'(vo_c), int'(vod_c),
                        int'(hs_c), int'(vs_c), int'(ls_c), int'(fs_c));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit found;
        int hold_x, hold_hs, tick_seen;

        reset_key = 1'b0;
        enable    = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        chk("rst.c_x", int'(px_c), 0);
        chk("rst.c_y", int'(py_c), 0);
        chk("rst.c_hs", int'(hs_c), 1);
        chk("rst.c_vs", int'(vs_c), 1);
        chk("rst.c_vod", int'(vod_c), 0);
        chk("rst.c_tick", int'(tick_c), 0);
        chk("rst.b_hs", int'(hs_b), 0);
        chk("rst.b_vs", int'(vs_b), 0);

        // Release: CLK_DIV=2 ticks on the second clock, CLK_DIV=1 on the first.
        cyc();
        reset_key = 1'b1;
        enable    = 1'b1;
        @(negedge clk);
        chk("first.c_tick0", int'(tick_c), 0);
        chk("first.b_fs", int'(fs_b), 1);
        cyc();
        @(negedge clk);
        chk("first.c_tick1", int'(tick_c), 1);
        chk("first.c_fs", int'(fs_c), 1);
        chk("first.c_ls", int'(ls_c), 1);

        // Simultaneous h/v wrap on the small configuration.
        found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            cyc();
            @(negedge clk);
            if (px_a == 4'd14 && py_a == 4'd7 && tick_a) found = 1'b1;
        end
        chk("wait.a_wrap", int'(found), 1);
        cyc();
        @(negedge clk);
        chk("wrap.a_x", int'(px_a), 0);
        chk("wrap.a_y", int'(py_a), 0);
        cyc();
        @(negedge clk);
        chk("wrap.a_tick", int'(tick_a), 1);
        chk("wrap.a_fs", int'(fs_a), 1);
        chk("wrap.a_ls", int'(ls_a), 1);

        // Delayed hsync edge on the default configuration.
        found = 1'b0;
        for (int k = 0; k < 4000 && !found; k++) begin
            cyc();
            @(negedge clk);
            if (px_c == 10'd656) found = 1'b1;
        end
        chk("wait.c_656", int'(found), 1);
        chk("hs.c_at656", int'(hs_c), 1);
        for (int k = 0; k < 3; k++) cyc();
        @(negedge clk);
        chk("hs.c_plus3clk", int'(hs_c), 1);
        cyc();
        @(negedge clk);
        chk("hs.c_plus4clk", int'(hs_c), 0);

        // Freeze mid-line for 37 clocks.
        cyc();
        enable = 1'b0;
        @(negedge clk);
        hold_x    = int'(px_c);
        hold_hs   = int'(hs_c);
        tick_seen = 0;
        for (int k = 0; k < 37; k++) begin
            if (tick_a || tick_b || tick_c || ls_c || fs_c) tick_seen++;
            cyc();
            @(negedge clk);
        end
        chk("freeze.ticks", tick_seen, 0);
        chk("freeze.c_x", int'(px_c), hold_x);
        chk("freeze.c_hs", int'(hs_c), hold_hs);
        cyc();
        enable = 1'b1;
        for (int k = 0; k < 40; k++) cyc();

        // Reset mid-frame.
        reset_key = 1'b0;
        cyc();
        reset_key = 1'b1;
        @(negedge clk);
        chk("midrst.c_x", int'(px_c), 0);
        chk("midrst.c_y", int'(py_c), 0);
        chk("midrst.c_hs", int'(hs_c), 1);
        chk("midrst.c_vs", int'(vs_c), 1);

        // Random enable gaps and rare resets, checked by the model every cycle.
        for (int k = 0; k < 25000; k++) begin
            cyc();
            enable    = ($urandom_range(0, 7) != 0);
            reset_key = ($urandom_range(0, 4999) != 0);
        end
        cyc();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
